mcb_cmd_arb: RTL
================

MCB_CMD_ARB -- requirements
Module: mcb_cmd_arb

Interface
REQ-001 Parameter pCL, default 2: CAS latency in mcb_clk cycles; legal values 2, 3.
REQ-002 Parameter pBL, default 4: burst length in cycles; legal values 1, 2, 4, 8.
REQ-003 mcb_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 mcb_rst  in  1  reset; synchronous, active-high.
REQ-005 mcb_sclr  in  1  synchronous abort, active-high.
REQ-006 rq0_req, rq1_req  in  1 each  requester command request; held high until the matching ack.
REQ-007 rq0_we, rq1_we  in  1 each  1 = write, 0 = read; stable while req is high.
REQ-008 rq0_ap, rq1_ap  in  1 each  1 = auto-precharge variant (c_rda/c_wra); stable while req is high.
REQ-009 rq0_bst, rq1_bst  in  2 each  burst count minus one; stable while req is high.
REQ-010 rq0_ack, rq1_ack  out  1 each  one-cycle grant pulse.
REQ-011 c_bst_num  out  2  burst count to the data control.
REQ-012 c_rd, c_rda, c_wr, c_wra  out  1 each  one-cycle command strobes to the data control.
REQ-013 c_wdat_req  out  1  one-cycle write-data prefetch strobe.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have exactly these states: IDLE, RCMD, RBUSY, WREQ, WCMD, WBUSY.
REQ-017 Arbitration SHALL occur only in IDLE: with one requester high, that requester is granted; with both high, the requester not granted last is granted (round-robin pointer).
REQ-018 On grant at edge E, the FSM SHALL leave IDLE at E and latch we, ap and bst of the granted port; ackN SHALL be high for exactly the cycle following E.
REQ-019 Read path: RCMD lasts 1 cycle with c_rd (ap=0) or c_rda (ap=1) high, then RBUSY for pCL + pBL*(bst+1) cycles, then IDLE.
REQ-020 Write path: WREQ lasts 1 cycle with c_wdat_req high, then WCMD for 1 cycle with c_wr (ap=0) or c_wra (ap=1) high, then WBUSY for pBL*(bst+1) cycles, then IDLE.
REQ-021 c_bst_num SHALL equal the latched bst from the first non-IDLE cycle through the last busy cycle, and SHALL return to 2'b00 in IDLE.
REQ-022 At most one of c_rd, c_rda, c_wr, c_wra, c_wdat_req SHALL be high in any cycle.
REQ-023 The busy-cycle counter SHALL be 6 bits wide and load the full count without overflow for every legal parameter/bst combination (maximum 3 + 8*4 = 35).
REQ-024 At least one IDLE cycle SHALL separate consecutive commands; a request held through IDLE is granted at that IDLE edge.
REQ-025 A req deasserted before ack SHALL NOT be granted and leaves no state behind; req high outside IDLE is ignored until IDLE.
REQ-026 mcb_sclr high in any state SHALL force IDLE at the next edge, clear all strobes, c_bst_num and the counter, suppress any pending ack, and preserve the round-robin pointer.
REQ-027 mcb_rst SHALL take priority over mcb_sclr.

Reset
REQ-028 When mcb_rst is high at an edge, the FSM SHALL go to IDLE; all outputs SHALL become 0 (c_bst_num = 2'b00); the counter SHALL clear; the round-robin pointer SHALL favour port 0 for the first contested grant.
REQ-029 Reset asserted mid-operation SHALL abort the operation identically, with no residual strobe after the reset edge.

Verification
REQ-030 Reset: assert mcb_rst 2 cycles with both reqs high -> all outputs 0 during reset; first grant afterward goes to rq0.
REQ-031 rq0 read, ap=1, bst=00, pCL=2, pBL=4 -> rq0_ack 1 cycle; c_rda 1 cycle; busy for 1+6 cycles; c_bst_num=00; IDLE after.
REQ-032 rq1 write, ap=0, bst=01 -> c_wdat_req 1 cycle, then c_wr 1 cycle with c_bst_num=01, WBUSY 8 cycles, busy high for 10 cycles total.
REQ-033 Both reqs held continuously, reads, bst=00 -> acks alternate rq0, rq1, rq0, rq1; each command is separated by exactly one IDLE cycle.
REQ-034 mcb_sclr pulsed during the 3rd RBUSY cycle of a bst=11 read -> IDLE and all outputs 0 next cycle; next contested grant follows the preserved pointer.
REQ-035 mcb_rst pulsed during the WCMD cycle -> c_wr low from the reset edge on, busy=0, no ack; a subsequent request is granted normally.

Source files
------------

// File: rtl/mcb_cmd_arb.sv
// ---------------------------------------------------------------------------
// mcb_cmd_arb
//   Two-port command arbiter for the memory controller data path. In IDLE it
//   grants one requester (round-robin when both ask). It then steps the read
//   or write command sequence, and holds busy until the data burst has
//   drained.
//
// Handshake: a requester raises rqN_req with rqN_we/ap/bst stable and holds
//   it until it sees the one-cycle rqN_ack pulse. Requests are only looked at
//   while the FSM is IDLE. Dropping req before the ack cancels the request
//   with no side effect.
//
// Ports
//   mcb_clk, mcb_rst        clock, synchronous active-high reset
//   mcb_sclr                synchronous abort back to IDLE (pointer kept)
//   rqN_req/we/ap/bst       requester N command (N = 0, 1)
//   rqN_ack                 one-cycle grant pulse
//   c_bst_num               latched burst count while busy, 0 in IDLE
//   c_rd/c_rda/c_wr/c_wra   one-cycle command strobes
//   c_wdat_req              one-cycle write-data prefetch strobe
//   busy                    high whenever the FSM is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module mcb_cmd_arb #(
   parameter int pCL = 2,   // CAS latency: 2 or 3
   parameter int pBL = 4    // burst length: 1, 2, 4 or 8
) (
   input  logic       mcb_clk,
   input  logic       mcb_rst,
   input  logic       mcb_sclr,
   input  logic       rq0_req,
   input  logic       rq0_we,
   input  logic       rq0_ap,
   input  logic [1:0] rq0_bst,
   input  logic       rq1_req,
   input  logic       rq1_we,
   input  logic       rq1_ap,
   input  logic [1:0] rq1_bst,
   output logic       rq0_ack,
   output logic       rq1_ack,
   output logic [1:0] c_bst_num,
   output logic       c_rd,
   output logic       c_rda,
   output logic       c_wr,
   output logic       c_wra,
   output logic       c_wdat_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RCMD  = 3'd1,
      RBUSY = 3'd2,
      WREQ  = 3'd3,
      WCMD  = 3'd4,
      WBUSY = 3'd5
   } state_t;

   localparam logic [5:0] CL6 = 6'(pCL);
   localparam logic [5:0] BL6 = 6'(pBL);

   state_t     state_q, state_d;
   logic       ap_q, ap_d;
   logic [1:0] bst_q, bst_d;
   logic [5:0] cnt_q, cnt_d;
   // 1 = port 1 was granted last, so port 0 wins the next contested grant
   logic       last_q, last_d;

   logic       rq0_ack_q, rq0_ack_d;
   logic       rq1_ack_q, rq1_ack_d;
   logic [1:0] c_bst_num_q, c_bst_num_d;
   logic       c_rd_q, c_rd_d;
   logic       c_rda_q, c_rda_d;
   logic       c_wr_q, c_wr_d;
   logic       c_wra_q, c_wra_d;
   logic       c_wdat_req_q, c_wdat_req_d;
   logic       busy_q, busy_d;

   logic       grant0, grant1;
   logic [5:0] beats;

   // Burst beats for the latched burst count. The widest value is 8 * 4 =
   // 32, and adding the CAS latency gives at most 35. Both fit in 6 bits.
   assign beats = BL6 * ({4'b0000, bst_q} + 6'd1);

   always_comb begin
      state_d = state_q;
      ap_d    = ap_q;
      bst_d   = bst_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant0  = 1'b0;
      grant1  = 1'b0;

      case (state_q)
         IDLE: begin
            grant0 = rq0_req && (!rq1_req || last_q);
            grant1 = rq1_req && (!rq0_req || !last_q);
            if (grant0) begin
               ap_d    = rq0_ap;
               bst_d   = rq0_bst;
               last_d  = 1'b0;
               state_d = rq0_we ? WREQ : RCMD;
            end else if (grant1) begin
               ap_d    = rq1_ap;
               bst_d   = rq1_bst;
               last_d  = 1'b1;
               state_d = rq1_we ? WREQ : RCMD;
            end
         end
         RCMD: begin
            cnt_d   = CL6 + beats;
            state_d = RBUSY;
         end
         WREQ: begin
            state_d = WCMD;
         end
         WCMD: begin
            cnt_d   = beats;
            state_d = WBUSY;
         end
         RBUSY, WBUSY: begin
            // The count loaded on entry equals the number of busy cycles.
            // Leave on the cycle that sees 1.
            if (cnt_q <= 6'd1) begin
               cnt_d   = 6'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort: no grant this edge, back to IDLE. The round-robin pointer
      // keeps its value.
      if (mcb_sclr) begin
         state_d = IDLE;
         cnt_d   = 6'd0;
         grant0  = 1'b0;
         grant1  = 1'b0;
         ap_d    = ap_q;
         bst_d   = bst_q;
         last_d  = last_q;
      end

      // Outputs are registered from the next state, so each strobe lines up
      // with the cycle in which the FSM occupies that state.
      rq0_ack_d    = grant0;
      rq1_ack_d    = grant1;
      busy_d       = (state_d != IDLE);
      c_bst_num_d  = (state_d != IDLE) ? bst_d : 2'b00;
      c_rd_d       = (state_d == RCMD) && !ap_d;
      c_rda_d      = (state_d == RCMD) &&  ap_d;
      c_wr_d       = (state_d == WCMD) && !ap_d;
      c_wra_d      = (state_d == WCMD) &&  ap_d;
      c_wdat_req_d = (state_d == WREQ);
   end

   always_ff @(posedge mcb_clk) begin
      if (mcb_rst) begin
         state_q      <= IDLE;
         ap_q         <= 1'b0;
         bst_q        <= 2'b00;
         cnt_q        <= 6'd0;
         last_q       <= 1'b1;
         rq0_ack_q    <= 1'b0;
         rq1_ack_q    <= 1'b0;
         c_bst_num_q  <= 2'b00;
         c_rd_q       <= 1'b0;
         c_rda_q      <= 1'b0;
         c_wr_q       <= 1'b0;
         c_wra_q      <= 1'b0;
         c_wdat_req_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ap_q         <= ap_d;
         bst_q        <= bst_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         rq0_ack_q    <= rq0_ack_d;
         rq1_ack_q    <= rq1_ack_d;
         c_bst_num_q  <= c_bst_num_d;
         c_rd_q       <= c_rd_d;
         c_rda_q      <= c_rda_d;
         c_wr_q       <= c_wr_d;
         c_wra_q      <= c_wra_d;
         c_wdat_req_q <= c_wdat_req_d;
         busy_q       <= busy_d;
      end
   end

   assign rq0_ack    = rq0_ack_q;
   assign rq1_ack    = rq1_ack_q;
   assign c_bst_num  = c_bst_num_q;
   assign c_rd       = c_rd_q;
   assign c_rda      = c_rda_q;
   assign c_wr       = c_wr_q;
   assign c_wra      = c_wra_q;
   assign c_wdat_req = c_wdat_req_q;
   assign busy       = busy_q;

endmodule
